mppt_po_tracker: RTL and testbench

//  Perturb-and-observe MPPT tracker: the stage directly upstream of the PWM generator.

---
 rtl/mppt_po_tracker_pkg.sv | 16 +
 rtl/mppt_mul_seq.sv | 52 +++++
 rtl/mppt_po_tracker.sv | 131 +++++++++++++
 tb/tb_mppt_po_tracker.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mppt_po_tracker_pkg.sv
// Shared definitions for the perturb-and-observe MPPT tracker: sample/duty width,
// product width and the controller state encoding.
package mppt_po_tracker_pkg;

    localparam int W  = 12;
    localparam int PW = 2 * W;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MUL    = 3'd1,
        ST_CMP    = 3'd2,
        ST_UPD    = 3'd3,
        ST_SETTLE = 3'd4
    } state_t;

endpackage

// File: rtl/mppt_mul_seq.sv
// Sequential W x W unsigned shift-add multiplier, one multiplier bit per cycle.
// done marks the final iteration; product is complete from the following cycle.
module mppt_mul_seq
    import mppt_po_tracker_pkg::*;
(
    input  logic          clock,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  multiplicand,
    input  logic [W-1:0]  multiplier,
    output logic          done,
    output logic [PW-1:0] product
);

    localparam int IW = $clog2(W);

    logic [PW-1:0] mcand_q;
    logic [PW-1:0] acc_q;
    logic [W-1:0]  mplier_q;
    logic [IW-1:0] iter_q;
    logic          busy_q;

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            iter_q   <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            mcand_q  <= {{W{1'b0}}, multiplicand};
            mplier_q <= multiplier;
            acc_q    <= '0;
            iter_q   <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            iter_q   <= iter_q + IW'(1);
            if (iter_q == IW'(W - 1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign done    = busy_q && (iter_q == IW'(W - 1));
    assign product = acc_q;

endmodule

// File: rtl/mppt_po_tracker.sv
// Perturb-and-observe MPPT: multiplies V*I, compares with the previous power and steps
// the clamped duty command, then idles for a settle window before taking the next sample.
module mppt_po_tracker
    import mppt_po_tracker_pkg::*;
#(
    parameter int DUTY_INIT     = 2048,
    parameter int DUTY_MIN      = 200,
    parameter int DUTY_MAX      = 3900,
    parameter int DUTY_STEP     = 16,
    parameter int DEADBAND      = 64,
    parameter int SETTLE_CYCLES = 20000
)(
    input  logic         clock,
    input  logic         rst_n,
    input  logic         sample_valid,
    output logic         sample_ready,
    input  logic [W-1:0] v_in,
    input  logic [W-1:0] i_in,
    output logic [W-1:0] duty_out,
    output logic         duty_valid,
    output logic         dir_up
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic signed [PW:0]  DB    = (PW+1)'(DEADBAND);
    localparam logic signed [W+1:0] STEP  = (W+2)'(DUTY_STEP);
    localparam logic signed [W+1:0] D_MAX = (W+2)'(DUTY_MAX);
    localparam logic signed [W+1:0] D_MIN = (W+2)'(DUTY_MIN);

    state_t          state_q, state_d;
    logic            mul_start, mul_done;
    logic [PW-1:0]   product;
    logic [PW-1:0]   p_prev_q;
    logic            first_q;
    logic            step_en_q;
    logic            dir_next_q;
    logic [CW-1:0]   settle_q;
    logic            settle_done;
    logic signed [PW:0]  dp;
    logic signed [W+1:0] nxt;

    assign sample_ready = (state_q == ST_IDLE);
    assign mul_start    = sample_ready && sample_valid;
    assign settle_done  = (int'(settle_q) == SETTLE_CYCLES - 1);

    mppt_mul_seq u_mul (
        .clock        (clock),
        .rst_n        (rst_n),
        .start        (mul_start),
        .multiplicand (v_in),
        .multiplier   (i_in),
        .done         (mul_done),
        .product      (product)
    );

    assign dp  = $signed({1'b0, product}) - $signed({1'b0, p_prev_q});
    assign nxt = dir_next_q ? ($signed({2'b00, duty_out}) + STEP)
                            : ($signed({2'b00, duty_out}) - STEP);

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (sample_valid) state_d = ST_MUL;
            ST_MUL:    if (mul_done) state_d = ST_CMP;
            ST_CMP:    state_d = ST_UPD;
            ST_UPD:    state_d = (SETTLE_CYCLES == 0) ? ST_IDLE : ST_SETTLE;
            ST_SETTLE: if (settle_done) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Decision is latched in CMP and applied in UPD; a clamp overrides the chosen direction.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            duty_out   <= W'(DUTY_INIT);
            duty_valid <= 1'b0;
            dir_up     <= 1'b1;
            first_q    <= 1'b1;
            p_prev_q   <= '0;
            settle_q   <= '0;
            step_en_q  <= 1'b0;
            dir_next_q <= 1'b1;
        end else begin
            duty_valid <= 1'b0;
            unique case (state_q)
                ST_CMP: begin
                    if (first_q || (dp > DB)) begin
                        step_en_q  <= 1'b1;
                        dir_next_q <= dir_up;
                    end else if (dp < -DB) begin
                        step_en_q  <= 1'b1;
                        dir_next_q <= ~dir_up;
                    end else begin
                        step_en_q  <= 1'b0;
                        dir_next_q <= dir_up;
                    end
                end
                ST_UPD: begin
                    duty_valid <= 1'b1;
                    p_prev_q   <= product;
                    first_q    <= 1'b0;
                    if (step_en_q) begin
                        if (nxt >= D_MAX) begin
                            duty_out <= W'(DUTY_MAX);
                            dir_up   <= 1'b0;
                        end else if (nxt <= D_MIN) begin
                            duty_out <= W'(DUTY_MIN);
                            dir_up   <= 1'b1;
                        end else begin
                            duty_out <= nxt[W-1:0];
                            dir_up   <= dir_next_q;
                        end
                    end
                end
                ST_SETTLE: begin
                    settle_q <= settle_done ? '0 : settle_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mppt_po_tracker.sv
// Randomized and directed bench for mppt_po_tracker against an arithmetic P&O model;
// instance 1 uses tight clamps so both limits are exercised.
module tb_mppt_po_tracker;

    localparam int SETTLE = 4;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_s [2];
    logic [11:0] v_s     [2];
    logic [11:0] i_s     [2];
    logic        ready_w [2];
    logic [11:0] duty_w  [2];
    logic        dv_w    [2];
    logic        dir_w   [2];

    int total = 0;
    int bad   = 0;

    longint m_duty  [2];
    bit     m_dir   [2];
    bit     m_first [2];
    longint m_pprev [2];
    longint m_max   [2] = '{3900, 2060};
    longint m_min   [2] = '{200, 2028};

    always #5 clock = ~clock;

    mppt_po_tracker #(.SETTLE_CYCLES(SETTLE)) dut_a (
        .clock(clock), .rst_n(rst_n),
        .sample_valid(valid_s[0]), .sample_ready(ready_w[0]),
        .v_in(v_s[0]), .i_in(i_s[0]),
        .duty_out(duty_w[0]), .duty_valid(dv_w[0]), .dir_up(dir_w[0])
    );

    mppt_po_tracker #(.SETTLE_CYCLES(SETTLE), .DUTY_MAX(2060), .DUTY_MIN(2028)) dut_b (
        .clock(clock), .rst_n(rst_n),
        .sample_valid(valid_s[1]), .sample_ready(ready_w[1]),
        .v_in(v_s[1]), .i_in(i_s[1]),
        .duty_out(duty_w[1]), .duty_valid(dv_w[1]), .dir_up(dir_w[1])
    );

    task automatic check_output(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_duty[k]  = 2048;
            m_dir[k]   = 1'b1;
            m_first[k] = 1'b1;
            m_pprev[k] = 0;
        end
    endtask

    // Hill-climb rule: keep going while power rises, reverse when it falls, hold in the deadband.
    task automatic model_update(input int idx, input longint v, input longint i);
        longint p, dp, target;
        bit     move;
        p    = v * i;
        dp   = p - m_pprev[idx];
        move = 1'b1;
        if (!m_first[idx]) begin
            if (dp < -64)      m_dir[idx] = ~m_dir[idx];
            else if (dp <= 64) move = 1'b0;
        end
        if (move) begin
            target = m_duty[idx] + (m_dir[idx] ? 16 : -16);
            if (target >= m_max[idx]) begin
                m_duty[idx] = m_max[idx];
                m_dir[idx]  = 1'b0;
            end else if (target <= m_min[idx]) begin
                m_duty[idx] = m_min[idx];
                m_dir[idx]  = 1'b1;
            end else begin
                m_duty[idx] = target;
            end
        end
        m_pprev[idx] = p;
        m_first[idx] = 1'b0;
    endtask

    task automatic apply_stimulus(input int idx, input logic [11:0] v, input logic [11:0] i,
                                  input bit drop_pulse);
        int n, lat, gap;
        n = 0;
        while (!ready_w[idx] && n < 200) begin
            @(posedge clock); #1; n++;
        end
        check_output("ready_before_sample", ready_w[idx], 1);
        valid_s[idx] = 1'b1; v_s[idx] = v; i_s[idx] = i;
        @(posedge clock); #1;
        valid_s[idx] = 1'b0;
        check_output("not_ready_when_busy", ready_w[idx], 0);
        lat = 0;
        while (!dv_w[idx] && lat < 100) begin
            @(posedge clock); #1; lat++;
            if (drop_pulse && lat == 5) begin
                valid_s[idx] = 1'b1; v_s[idx] = 12'hFFF; i_s[idx] = 12'hFFF;
            end else begin
                valid_s[idx] = 1'b0;
            end
        end
        check_output("latency", lat, 14);
        model_update(idx, longint'(v), longint'(i));
        check_output("duty_out", duty_w[idx], m_duty[idx]);
        check_output("dir_up", dir_w[idx], m_dir[idx]);
        @(posedge clock); #1;
        check_output("duty_valid_width", dv_w[idx], 0);
        gap = 1;
        while (!ready_w[idx] && gap < 100) begin
            @(posedge clock); #1; gap++;
        end
        check_output("settle_gap", gap, SETTLE);
    endtask

    task automatic reset_abort();
        int pulses, n;
        n = 0;
        while (!ready_w[0] && n < 200) begin
            @(posedge clock); #1; n++;
        end
        valid_s[0] = 1'b1; v_s[0] = 12'd1234; i_s[0] = 12'd2345;
        @(posedge clock); #1;
        valid_s[0] = 1'b0;
        pulses = 0;
        repeat (5) begin
            @(posedge clock); #1; pulses += int'(dv_w[0]);
        end
        rst_n = 1'b0;
        @(posedge clock); #1;
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clock); #1; pulses += int'(dv_w[0]);
        end
        model_reset();
        check_output("abort_no_pulse", pulses, 0);
        check_output("abort_duty", duty_w[0], 2048);
        check_output("abort_dir", dir_w[0], 1);
        check_output("abort_ready", ready_w[0], 1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [11:0] rv, ri;
        for (int k = 0; k < 2; k++) begin
            valid_s[k] = 1'b0; v_s[k] = '0; i_s[k] = '0;
        end
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clock);
        #1 rst_n = 1'b1;
        @(posedge clock); #1;
        check_output("reset_duty", duty_w[0], 2048);
        check_output("reset_valid", dv_w[0], 0);
        check_output("reset_dir", dir_w[0], 1);
        check_output("reset_ready", ready_w[0], 1);

        apply_stimulus(1, 12'd1000, 12'd1000, 1'b0);
        apply_stimulus(1, 12'd1000, 12'd1100, 1'b0);
        apply_stimulus(1, 12'd1000, 12'd1200, 1'b0);
        apply_stimulus(1, 12'd1000, 12'd1300, 1'b0);

        apply_stimulus(0, 12'd1000, 12'd1000, 1'b0);
        check_output("first_step_duty", duty_w[0], 2064);
        apply_stimulus(0, 12'd1000, 12'd1100, 1'b0);
        apply_stimulus(0, 12'd1000, 12'd900, 1'b0);
        apply_stimulus(0, 12'd2350, 12'd383, 1'b0);
        check_output("deadband_hold", duty_w[0], 2064);
        apply_stimulus(0, 12'd1000, 12'd950, 1'b1);

        reset_abort();
        apply_stimulus(0, 12'd1000, 12'd500, 1'b0);
        check_output("first_after_abort", duty_w[0], 2064);

        rv = 12'd1000; ri = 12'd500;
        for (int n = 0; n < 14; n++) begin
            if ($urandom_range(0, 3) != 0) begin
                rv = 12'($urandom_range(0, 4095));
                ri = 12'($urandom_range(0, 4095));
            end
            apply_stimulus(0, rv, ri, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
